// File: rtl/sqrt_fx_pkg.sv
// sqrt_fx_pkg: shared constants and state encoding for the fixed-point
// square-root unit.
//   SQRT_WIDTH  operand/result width (signed Q12.13)
//   SQRT_FRAC   number of fractional bits
//   SQRT_TAG_W  sideband tag width
//   SQRT_RAD_W  radicand width (WIDTH-1+FRAC rounded up to even)
//   SQRT_ITER   iterations per operation (one result bit each)
//   SQRT_CNT_W  iteration counter width
package sqrt_fx_pkg;

  localparam int SQRT_WIDTH = 26;
  localparam int SQRT_FRAC  = 13;
  localparam int SQRT_TAG_W = 4;
  localparam int SQRT_RAD_W = ((SQRT_WIDTH - 1 + SQRT_FRAC + 1) / 2) * 2;
  localparam int SQRT_ITER  = SQRT_RAD_W / 2;
  localparam int SQRT_CNT_W = $clog2(SQRT_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational iteration of the restoring digit-by-digit
// square root. Shifts two radicand bits into the partial remainder and
// tries to subtract the trial value (root<<2)|1.
//   rem       current partial remainder (ITER+2 bits)
//   root      current partial root (ITER bits)
//   rad_bits  next two radicand bits, MSB first
//   rem_next  remainder after this iteration
//   root_next root after this iteration (one more result bit)
module sqrt_step #(
  parameter int ITER = 19
) (
  input  logic [ITER+1:0] rem,
  input  logic [ITER-1:0] root,
  input  logic [1:0]      rad_bits,
  output logic [ITER+1:0] rem_next,
  output logic [ITER-1:0] root_next
);

  logic [ITER+3:0] shifted;
  logic [ITER+3:0] trial;
  logic [ITER+1:0] diff;

  // The shifted remainder needs two extra bits for the comparison, but when
  // the subtraction is taken the true difference always fits in ITER+2 bits,
  // so the narrow modular subtraction is exact.
  always_comb begin
    shifted   = {rem, rad_bits};
    trial     = {2'b00, root, 2'b01};
    diff      = shifted[ITER+1:0] - trial[ITER+1:0];
    rem_next  = shifted[ITER+1:0];
    root_next = {root[ITER-2:0], 1'b0};
    if (shifted >= trial) begin
      rem_next  = diff;
      root_next = {root[ITER-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sqrt_fx.sv
// sqrt_fx: iterative signed Q12.13 square root, floor(sqrt(x)), one result
// bit per clock. Negative operands complete immediately with err_out set.
//   clk_sqrt    clock
//   rst_sqrt    synchronous active-high reset
//   en_sqrt     start request, taken when ready_sqrt=1
//   x_in        signed Q12.13 operand
//   tag_in      sideband tag captured with x_in
//   ready_sqrt  high in IDLE or DONE
//   valid_sqrt  one-cycle pulse marking y_out/err_out/tag_out valid
//   y_out       floor(sqrt(x)) in Q12.13, never negative
//   err_out     operand was negative
//   tag_out     tag of the completed operation
module sqrt_fx
  import sqrt_fx_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH,
  parameter int FRAC  = SQRT_FRAC,
  parameter int TAG_W = SQRT_TAG_W
) (
  input  logic             clk_sqrt,
  input  logic             rst_sqrt,
  input  logic             en_sqrt,
  input  logic [WIDTH-1:0] x_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             ready_sqrt,
  output logic             valid_sqrt,
  output logic [WIDTH-1:0] y_out,
  output logic             err_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int RAD_W = ((WIDTH - 1 + FRAC + 1) / 2) * 2;
  localparam int ITER  = RAD_W / 2;
  localparam int CNT_W = $clog2(ITER);

  sqrt_state_t state, next_state;

  logic [RAD_W-1:0] rad;
  logic [ITER+1:0]  rem, rem_next;
  logic [ITER-1:0]  root, root_next;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             x_neg;

  assign ready_sqrt = (state == IDLE) || (state == DONE);
  assign valid_sqrt = (state == DONE);
  assign accept     = ready_sqrt && en_sqrt;
  assign x_neg      = x_in[WIDTH-1];

  sqrt_step #(.ITER(ITER)) u_step (
    .rem       (rem),
    .root      (root),
    .rad_bits  (rad[RAD_W-1:RAD_W-2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // State register.
  always_ff @(posedge clk_sqrt) begin
    if (rst_sqrt) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: negative operands skip RUN and complete at once;
  // requests seen during RUN are dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (en_sqrt) begin
          next_state = x_neg ? DONE : RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate during RUN, and register the result
  // on the edge that enters DONE so outputs hold until the next completion.
  always_ff @(posedge clk_sqrt) begin
    if (rst_sqrt) begin
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      tag_q   <= '0;
      y_out   <= '0;
      err_out <= 1'b0;
      tag_out <= '0;
    end else if (accept) begin
      tag_q <= tag_in;
      if (x_neg) begin
        y_out   <= '0;
        err_out <= 1'b1;
        tag_out <= tag_in;
      end else begin
        rad  <= RAD_W'({x_in[WIDTH-2:0], {FRAC{1'b0}}});
        rem  <= '0;
        root <= '0;
        cnt  <= CNT_W'(ITER - 1);
      end
    end else if (state == RUN) begin
      rad  <= {rad[RAD_W-3:0], 2'b00};
      rem  <= rem_next;
      root <= root_next;
      cnt  <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        y_out   <= WIDTH'(root_next);
        err_out <= 1'b0;
        tag_out <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_fx.sv
// tb_sqrt_fx: self-checking bench for sqrt_fx. Expected results are pushed
// to a scoreboard queue when an operand is driven and popped when the DUT
// raises valid_sqrt.
module tb_sqrt_fx;

  logic        clk;
  logic        rst;
  logic        en;
  logic [25:0] x;
  logic [3:0]  tag;
  logic        ready;
  logic        valid;
  logic [25:0] y;
  logic        err;
  logic [3:0]  tag_o;

  typedef struct {
    logic [25:0] y;
    logic        err;
    logic [3:0]  tag;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  sqrt_fx dut (
    .clk_sqrt   (clk),
    .rst_sqrt   (rst),
    .en_sqrt    (en),
    .x_in       (x),
    .tag_in     (tag),
    .ready_sqrt (ready),
    .valid_sqrt (valid),
    .y_out      (y),
    .err_out    (err),
    .tag_out    (tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer square root by binary search.
  function automatic logic [25:0] model_sqrt(input logic [25:0] xv);
    longint r, lo, hi, mid;
    r  = longint'(xv[24:0]);
    r  = r << 13;
    lo = 0;
    hi = 64'd1 << 20;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid - 1;
    end
    return 26'(lo);
  endfunction

  // Drive one request across its accept edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [25:0] xv, input logic [3:0] tv);
    en  = 1'b1;
    x   = xv;
    tag = tv;
    @(posedge clk);
    #1;
    en  = 1'b0;
  endtask

  // Edges from the accept edge (counted as 1) until valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!valid) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b0;
    x   = '0;
    tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_compared++;
    if (ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ready got=%b want=1", ready);
    end
    n_compared++;
    if (valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid got=%b want=0", valid);
    end
    n_compared++;
    if (y !== 26'd0 || err !== 1'b0 || tag_o !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs got y=%0d err=%b tag=%0d want 0/0/0", y, err, tag_o);
    end
  endtask

  task automatic test_values;
    logic [25:0] xs [6] = '{26'd8192, 26'd16384, 26'd2048, 26'd1, 26'd33554431, 26'd0};
    logic [25:0] ys [6] = '{26'd8192, 26'd11585, 26'd4096, 26'd90, 26'd524287, 26'd0};
    logic [3:0]  ts [6] = '{4'd3, 4'd1, 4'd2, 4'd4, 4'd6, 4'd0};
    for (int i = 0; i < 10; i++) begin
      exp_t        e;
      exp_t        g;
      logic [25:0] xv;
      int          lat;
      if (i < 6) begin
        xv    = xs[i];
        e.y   = ys[i];
        e.tag = ts[i];
      end else begin
        xv    = 26'($urandom_range(0, 33554431));
        e.y   = model_sqrt(xv);
        e.tag = 4'($urandom_range(0, 15));
      end
      e.err = 1'b0;
      e.lat = 20;
      n_compared++;
      if (ready !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL ready_before_op x=%0d got=%b want=1", xv, ready);
      end
      sb.push_back(e);
      applyStimulus(xv, e.tag);
      wait_valid(lat);
      g = sb.pop_front();
      n_compared++;
      if (lat != g.lat) begin
        n_mismatched++;
        $display("[TB] FAIL latency x=%0d got=%0d want=%0d", xv, lat, g.lat);
      end
      n_compared++;
      if (y !== g.y) begin
        n_mismatched++;
        $display("[TB] FAIL y_out x=%0d got=%0d want=%0d", xv, y, g.y);
      end
      n_compared++;
      if (err !== g.err || tag_o !== g.tag) begin
        n_mismatched++;
        $display("[TB] FAIL err_tag x=%0d got err=%b tag=%0d want err=%b tag=%0d",
                 xv, err, tag_o, g.err, g.tag);
      end
      @(posedge clk);
      #1;
      n_compared++;
      if (valid !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL valid_one_cycle x=%0d got=%b want=0", xv, valid);
      end
    end
  endtask

  task automatic test_negative;
    logic [25:0] xs [3] = '{26'h3FFFFFF, 26'h2000000, 26'h2ABCDEF};
    logic [3:0]  ts [3] = '{4'd5, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      exp_t g;
      int   lat;
      e.y   = 26'd0;
      e.err = 1'b1;
      e.tag = ts[i];
      e.lat = 1;
      sb.push_back(e);
      applyStimulus(xs[i], ts[i]);
      wait_valid(lat);
      g = sb.pop_front();
      n_compared++;
      if (lat != g.lat) begin
        n_mismatched++;
        $display("[TB] FAIL neg_latency x=%h got=%0d want=%0d", xs[i], lat, g.lat);
      end
      n_compared++;
      if (y !== g.y || err !== g.err || tag_o !== g.tag) begin
        n_mismatched++;
        $display("[TB] FAIL neg_result x=%h got y=%0d err=%b tag=%0d want y=%0d err=%b tag=%0d",
                 xs[i], y, err, tag_o, g.y, g.err, g.tag);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // en held high: the second operand is taken on the edge ending the DONE
  // cycle, and the third request lands in RUN and must be dropped.
  task automatic test_back_to_back;
    exp_t e1, e2, g;
    int   cyc;
    int   nres;
    int   first_cyc;
    int   second_cyc;
    int   spurious;
    e1.y = 26'd8192; e1.err = 1'b0; e1.tag = 4'd1; e1.lat = 0;
    e2.y = 26'd4096; e2.err = 1'b0; e2.tag = 4'd2; e2.lat = 0;
    sb.push_back(e1);
    sb.push_back(e2);
    en         = 1'b1;
    x          = 26'd8192;
    tag        = 4'd1;
    cyc        = 0;
    nres       = 0;
    first_cyc  = 0;
    second_cyc = 0;
    while (nres < 2 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        x   = 26'd2048;
        tag = 4'd2;
      end
      if (cyc == 21) begin
        x   = 26'd16384;
        tag = 4'd7;
      end
      if (cyc == 26) en = 1'b0;
      if (valid) begin
        n_compared++;
        if (sb.size() == 0) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_unexpected_valid got y=%0d want no result", y);
        end else begin
          g = sb.pop_front();
          if (y !== g.y || err !== g.err || tag_o !== g.tag) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_result got y=%0d err=%b tag=%0d want y=%0d err=%b tag=%0d",
                     y, err, tag_o, g.y, g.err, g.tag);
          end
        end
        if (nres == 0) first_cyc = cyc;
        else second_cyc = cyc;
        nres++;
      end
    end
    en = 1'b0;
    n_compared++;
    if (nres != 2) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_result_count got=%0d want=2", nres);
    end
    n_compared++;
    if (first_cyc != 20) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_first_latency got=%0d want=20", first_cyc);
    end
    // Accept on the DONE edge, then 19 RUN edges: 19 idle cycles between pulses.
    n_compared++;
    if (second_cyc - first_cyc != 20) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_spacing got=%0d want=20", second_cyc - first_cyc);
    end
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid) spurious++;
    end
    n_compared++;
    if (spurious != 0 || sb.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_dropped_request got valids=%0d pending=%0d want 0/0",
               spurious, sb.size());
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    exp_t g;
    int   spurious;
    int   lat;
    applyStimulus(26'd16384, 4'd9);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_compared++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_handshake got ready=%b valid=%b want 1/0", ready, valid);
    end
    n_compared++;
    if (y !== 26'd0 || err !== 1'b0 || tag_o !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_outputs got y=%0d err=%b tag=%0d want 0/0/0", y, err, tag_o);
    end
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid) spurious++;
    end
    n_compared++;
    if (spurious != 0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_no_valid got=%0d want=0", spurious);
    end
    e.y   = model_sqrt(26'd4096);
    e.err = 1'b0;
    e.tag = 4'd12;
    e.lat = 20;
    sb.push_back(e);
    applyStimulus(26'd4096, 4'd12);
    wait_valid(lat);
    g = sb.pop_front();
    n_compared++;
    if (lat != g.lat || y !== g.y || tag_o !== g.tag || err !== g.err) begin
      n_mismatched++;
      $display("[TB] FAIL abort_recovery got lat=%0d y=%0d tag=%0d err=%b want lat=%0d y=%0d tag=%0d err=%b",
               lat, y, tag_o, err, g.lat, g.y, g.tag, g.err);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_values();
    test_negative();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
